// File: rtl/alu_fwd_ctrl_if.sv
// Operand-select types and the ID/EX control bundle shared by the pipeline and
// the EX-stage forwarding controller.
package alu_fwd_ctrl_pkg;
  typedef enum logic [1:0] {
    RS1_S1   = 2'd0,
    PC_S1    = 2'd1,
    RD_MA_S1 = 2'd2,
    RD_WB_S1 = 2'd3
  } ctrlAluSrc1_e;

  typedef enum logic [1:0] {
    RS2_S2   = 2'd0,
    IMM_S2   = 2'd1,
    RD_MA_S2 = 2'd2,
    RD_WB_S2 = 2'd3
  } ctrlAluSrc2_e;
endpackage

interface alu_fwd_ctrl_if
  import alu_fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
);
  logic              id_valid;
  ctrlAluSrc1_e      id_src1;
  ctrlAluSrc2_e      id_src2;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  ctrlAluSrc1_e      ex_alu_src1;
  ctrlAluSrc2_e      ex_alu_src2;
  logic              ex_valid;
  logic              stall;

  modport master (
    output id_valid, id_src1, id_src2, id_rs1, id_rs2, id_rs2_used, id_rd,
           id_reg_write, id_mem_read, flush,
    input  ex_alu_src1, ex_alu_src2, ex_valid, stall
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_rs1, id_rs2, id_rs2_used, id_rd,
           id_reg_write, id_mem_read, flush,
    output ex_alu_src1, ex_alu_src2, ex_valid, stall
  );
endinterface

// File: rtl/alu_fwd_ctrl.sv
// EX-stage forwarding and load-use hazard controller: registers ALU operand
// selects at ID->EX, stalls on load-use, honours flushes, counts stalls/forwards.
module alu_fwd_ctrl
  import alu_fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             clk_en,
  input  logic             rst,
  alu_fwd_ctrl_if.slave    bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);
  localparam int unsigned CW1 = CNT_W + 1;

  logic              ex_v_q, ex_we_q, ex_ld_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              ma_v_q, ma_we_q;
  logic [REG_AW-1:0] ma_rd_q;
  ctrlAluSrc1_e      src1_q, src1_d;
  ctrlAluSrc2_e      src2_q, src2_d;
  logic              ex_valid_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

  logic              hit_x1, hit_x2, hit_m1, hit_m2;
  logic              use1, use2, stall, advance;
  logic [1:0]        fwd_inc;
  logic [CW1-1:0]    stall_sum, fwd_sum;

  always_comb begin
    hit_x1 = ex_v_q & ex_we_q & (ex_rd_q == bus.id_rs1) & (bus.id_rs1 != '0);
    hit_x2 = ex_v_q & ex_we_q & (ex_rd_q == bus.id_rs2) & (bus.id_rs2 != '0);
    hit_m1 = ma_v_q & ma_we_q & (ma_rd_q == bus.id_rs1) & (bus.id_rs1 != '0);
    hit_m2 = ma_v_q & ma_we_q & (ma_rd_q == bus.id_rs2) & (bus.id_rs2 != '0);

    use1 = (bus.id_src1 == RS1_S1);
    use2 = (bus.id_src2 == RS2_S2);

    // Youngest producer (EX) wins over the older one (MA).
    src1_d = RS1_S1;
    if (!use1)       src1_d = PC_S1;
    else if (hit_x1) src1_d = RD_MA_S1;
    else if (hit_m1) src1_d = RD_WB_S1;

    src2_d = RS2_S2;
    if (!use2)       src2_d = IMM_S2;
    else if (hit_x2) src2_d = RD_MA_S2;
    else if (hit_m2) src2_d = RD_WB_S2;

    stall = bus.id_valid & ex_ld_q & ~bus.flush &
            ((use1 & hit_x1) | ((use2 | bus.id_rs2_used) & hit_x2));
    advance = bus.id_valid & ~stall & ~bus.flush;

    fwd_inc = '0;
    if (advance) begin
      fwd_inc = 2'(use1 & (hit_x1 | hit_m1)) + 2'(use2 & (hit_x2 | hit_m2));
    end

    stall_sum   = {1'b0, stall_cnt_q} + CW1'(stall);
    stall_cnt_d = stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
    fwd_sum     = {1'b0, fwd_cnt_q} + CW1'(fwd_inc);
    fwd_cnt_d   = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q      <= 1'b0;
      ex_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_rd_q     <= '0;
      ma_v_q      <= 1'b0;
      ma_we_q     <= 1'b0;
      ma_rd_q     <= '0;
      src1_q      <= RS1_S1;
      src2_q      <= RS2_S2;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (clk_en) begin
      ma_v_q      <= ex_v_q;
      ma_we_q     <= ex_we_q;
      ma_rd_q     <= ex_rd_q;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
      if (bus.flush || stall) begin
        // Bubble into EX; a stalled instruction keeps its selects for the retry.
        ex_v_q     <= 1'b0;
        ex_we_q    <= 1'b0;
        ex_ld_q    <= 1'b0;
        ex_valid_q <= 1'b0;
        if (!stall) begin
          src1_q <= src1_d;
          src2_q <= src2_d;
        end
      end else begin
        ex_v_q     <= bus.id_valid;
        ex_we_q    <= bus.id_reg_write;
        ex_ld_q    <= bus.id_mem_read;
        ex_rd_q    <= bus.id_rd;
        ex_valid_q <= bus.id_valid;
        src1_q     <= src1_d;
        src2_q     <= src2_d;
      end
    end
  end

  assign bus.stall       = stall;
  assign bus.ex_alu_src1 = src1_q;
  assign bus.ex_alu_src2 = src2_q;
  assign bus.ex_valid    = ex_valid_q;
  assign stall_cnt       = stall_cnt_q;
  assign fwd_cnt         = fwd_cnt_q;
endmodule

// File: tb/tb_alu_fwd_ctrl.sv
// Directed bench for alu_fwd_ctrl; a second 2-bit-counter instance mirrors the
// same stimulus to exercise counter saturation.
module tb_alu_fwd_ctrl;
  import alu_fwd_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        clk_en;
  logic        rst;
  logic [31:0] stall_cnt, fwd_cnt;
  logic [1:0]  sm_stall_cnt, sm_fwd_cnt;
  int          total = 0;
  int          bad = 0;

  alu_fwd_ctrl_if #(.REG_AW(5)) bus ();
  alu_fwd_ctrl_if #(.REG_AW(5)) bus2 ();

  assign bus2.id_valid     = bus.id_valid;
  assign bus2.id_src1      = bus.id_src1;
  assign bus2.id_src2      = bus.id_src2;
  assign bus2.id_rs1       = bus.id_rs1;
  assign bus2.id_rs2       = bus.id_rs2;
  assign bus2.id_rs2_used  = bus.id_rs2_used;
  assign bus2.id_rd        = bus.id_rd;
  assign bus2.id_reg_write = bus.id_reg_write;
  assign bus2.id_mem_read  = bus.id_mem_read;
  assign bus2.flush        = bus.flush;

  alu_fwd_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk       (clk),
    .clk_en    (clk_en),
    .rst       (rst),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .fwd_cnt   (fwd_cnt)
  );

  alu_fwd_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sm (
    .clk       (clk),
    .clk_en    (clk_en),
    .rst       (rst),
    .bus       (bus2),
    .stall_cnt (sm_stall_cnt),
    .fwd_cnt   (sm_fwd_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input ctrlAluSrc1_e s1, input ctrlAluSrc2_e s2,
                       input int rs1, input int rs2, input logic rs2_used, input int rd,
                       input logic we, input logic ld);
    bus.id_valid     = v;
    bus.id_src1      = s1;
    bus.id_src2      = s2;
    bus.id_rs1       = 5'(rs1);
    bus.id_rs2       = 5'(rs2);
    bus.id_rs2_used  = rs2_used;
    bus.id_rd        = 5'(rd);
    bus.id_reg_write = we;
    bus.id_mem_read  = ld;
    #1;
  endtask

  task automatic nop();
    issue(1'b0, RS1_S1, RS2_S2, 0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop();
    step();
    rst = 1'b0;
    clk_en = 1'b1;
  endtask

  task automatic test_reset();
    bus.flush = 1'b0;
    clk_en = 1'b0;
    rst = 1'b1;
    nop();
    step();
    total++; if (bus.ex_alu_src1 !== RS1_S1) begin bad++; $display("FAIL reset_src1 got=%0d want=%0d", bus.ex_alu_src1, RS1_S1); end
    total++; if (bus.ex_alu_src2 !== RS2_S2) begin bad++; $display("FAIL reset_src2 got=%0d want=%0d", bus.ex_alu_src2, RS2_S2); end
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%0b want=0", bus.ex_valid); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", bus.stall); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
    total++; if (fwd_cnt !== 32'd0) begin bad++; $display("FAIL reset_fwd_cnt got=%0d want=0", fwd_cnt); end
    rst = 1'b0;
    clk_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(1'b1, RS1_S1, RS2_S2, 1, 2, 1'b0, 5, 1'b1, 1'b0);  // ADD x5,x1,x2
    step();
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got=%0b want=1", bus.ex_valid); end
    issue(1'b1, RS1_S1, RS2_S2, 5, 7, 1'b0, 6, 1'b1, 1'b0);  // ADD x6,x5,x7
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%0b want=0", bus.stall); end
    step();
    total++; if (bus.ex_alu_src1 !== RD_MA_S1) begin bad++; $display("FAIL b2b_src1 got=%0d want=%0d", bus.ex_alu_src1, RD_MA_S1); end
    total++; if (bus.ex_alu_src2 !== RS2_S2) begin bad++; $display("FAIL b2b_src2 got=%0d want=%0d", bus.ex_alu_src2, RS2_S2); end
    total++; if (fwd_cnt !== 32'd1) begin bad++; $display("FAIL b2b_fwd_cnt got=%0d want=1", fwd_cnt); end
    nop();
    step();
  endtask

  task automatic test_distance_two();
    do_reset();
    issue(1'b1, RS1_S1, RS2_S2, 1, 2, 1'b0, 5, 1'b1, 1'b0);  // writes x5
    step();
    issue(1'b1, RS1_S1, RS2_S2, 3, 4, 1'b0, 7, 1'b1, 1'b0);  // writes x7
    step();
    issue(1'b1, RS1_S1, RS2_S2, 5, 7, 1'b0, 6, 1'b1, 1'b0);  // ADD x6,x5,x7
    step();
    total++; if (bus.ex_alu_src1 !== RD_WB_S1) begin bad++; $display("FAIL d2_src1 got=%0d want=%0d", bus.ex_alu_src1, RD_WB_S1); end
    total++; if (bus.ex_alu_src2 !== RD_MA_S2) begin bad++; $display("FAIL d2_src2 got=%0d want=%0d", bus.ex_alu_src2, RD_MA_S2); end
    total++; if (fwd_cnt !== 32'd2) begin bad++; $display("FAIL d2_fwd_cnt got=%0d want=2", fwd_cnt); end
    issue(1'b1, RS1_S1, RS2_S2, 1, 2, 1'b0, 5, 1'b1, 1'b0);  // x5 at distance 2
    step();
    issue(1'b1, RS1_S1, RS2_S2, 3, 4, 1'b0, 5, 1'b1, 1'b0);  // x5 at distance 1
    step();
    issue(1'b1, RS1_S1, RS2_S2, 5, 2, 1'b0, 6, 1'b1, 1'b0);  // ADD x6,x5,x2
    step();
    total++; if (bus.ex_alu_src1 !== RD_MA_S1) begin bad++; $display("FAIL prio_src1 got=%0d want=%0d", bus.ex_alu_src1, RD_MA_S1); end
    total++; if (fwd_cnt !== 32'd3) begin bad++; $display("FAIL prio_fwd_cnt got=%0d want=3", fwd_cnt); end
    nop();
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    issue(1'b1, RS1_S1, IMM_S2, 1, 0, 1'b0, 5, 1'b1, 1'b1);  // LW x5
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_stall_pre got=%0b want=0", bus.stall); end
    step();
    issue(1'b1, RS1_S1, RS2_S2, 5, 1, 1'b0, 6, 1'b1, 1'b0);  // ADD x6,x5,x1
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b want=1", bus.stall); end
    step();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0b want=0", bus.ex_valid); end
    total++; if (bus.ex_alu_src2 !== IMM_S2) begin bad++; $display("FAIL lu_src2_held got=%0d want=%0d", bus.ex_alu_src2, IMM_S2); end
    total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d want=1", stall_cnt); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%0b want=0", bus.stall); end
    step();
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL lu_valid got=%0b want=1", bus.ex_valid); end
    total++; if (bus.ex_alu_src1 !== RD_WB_S1) begin bad++; $display("FAIL lu_src1 got=%0d want=%0d", bus.ex_alu_src1, RD_WB_S1); end
    total++; if (bus.ex_alu_src2 !== RS2_S2) begin bad++; $display("FAIL lu_src2 got=%0d want=%0d", bus.ex_alu_src2, RS2_S2); end
    total++; if (fwd_cnt !== 32'd1) begin bad++; $display("FAIL lu_fwd_cnt got=%0d want=1", fwd_cnt); end
    nop();
    step();
  endtask

  task automatic test_store_after_load();
    do_reset();
    issue(1'b1, RS1_S1, IMM_S2, 1, 0, 1'b0, 5, 1'b1, 1'b1);  // LW x5
    step();
    issue(1'b1, RS1_S1, IMM_S2, 2, 5, 1'b1, 0, 1'b0, 1'b0);  // SW x5,0(x2)
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL st_stall got=%0b want=1", bus.stall); end
    step();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL st_bubble got=%0b want=0", bus.ex_valid); end
    step();
    total++; if (bus.ex_alu_src2 !== IMM_S2) begin bad++; $display("FAIL st_src2 got=%0d want=%0d", bus.ex_alu_src2, IMM_S2); end
    total++; if (bus.ex_alu_src1 !== RS1_S1) begin bad++; $display("FAIL st_src1 got=%0d want=%0d", bus.ex_alu_src1, RS1_S1); end
    total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL st_stall_cnt got=%0d want=1", stall_cnt); end
    total++; if (fwd_cnt !== 32'd0) begin bad++; $display("FAIL st_fwd_cnt got=%0d want=0", fwd_cnt); end
    nop();
    step();
  endtask

  task automatic test_x0_and_flush();
    do_reset();
    issue(1'b1, RS1_S1, IMM_S2, 1, 0, 1'b0, 0, 1'b1, 1'b1);  // LW x0
    step();
    issue(1'b1, RS1_S1, RS2_S2, 0, 0, 1'b0, 6, 1'b1, 1'b0);  // ADD x6,x0,x0
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL x0_stall got=%0b want=0", bus.stall); end
    step();
    total++; if (bus.ex_alu_src1 !== RS1_S1) begin bad++; $display("FAIL x0_src1 got=%0d want=%0d", bus.ex_alu_src1, RS1_S1); end
    total++; if (bus.ex_alu_src2 !== RS2_S2) begin bad++; $display("FAIL x0_src2 got=%0d want=%0d", bus.ex_alu_src2, RS2_S2); end
    issue(1'b1, RS1_S1, IMM_S2, 1, 0, 1'b0, 5, 1'b1, 1'b1);  // LW x5
    step();
    bus.flush = 1'b1;
    issue(1'b1, RS1_S1, RS2_S2, 5, 1, 1'b0, 6, 1'b1, 1'b0);  // ADD x6,x5,x1
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL fl_stall got=%0b want=0", bus.stall); end
    step();
    bus.flush = 1'b0;
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL fl_bubble got=%0b want=0", bus.ex_valid); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL fl_stall_cnt got=%0d want=0", stall_cnt); end
    total++; if (fwd_cnt !== 32'd0) begin bad++; $display("FAIL fl_fwd_cnt got=%0d want=0", fwd_cnt); end
    nop();
    step();
  endtask

  task automatic test_enable_reset();
    do_reset();
    issue(1'b1, RS1_S1, IMM_S2, 1, 0, 1'b0, 5, 1'b1, 1'b1);  // LW x5
    step();
    issue(1'b1, RS1_S1, RS2_S2, 5, 1, 1'b0, 6, 1'b1, 1'b0);
    clk_en = 1'b0;
    repeat (3) step();
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL en_stall_held got=%0b want=1", bus.stall); end
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL en_valid_held got=%0b want=1", bus.ex_valid); end
    total++; if (bus.ex_alu_src2 !== IMM_S2) begin bad++; $display("FAIL en_src2_held got=%0d want=%0d", bus.ex_alu_src2, IMM_S2); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL en_stall_cnt_held got=%0d want=0", stall_cnt); end
    clk_en = 1'b1;
    step();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL en_bubble got=%0b want=0", bus.ex_valid); end
    total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL en_stall_cnt got=%0d want=1", stall_cnt); end
    step();
    issue(1'b1, RS1_S1, IMM_S2, 1, 0, 1'b0, 5, 1'b1, 1'b1);  // LW x5
    step();
    issue(1'b1, RS1_S1, RS2_S2, 5, 1, 1'b0, 6, 1'b1, 1'b0);
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rs_stall_pre got=%0b want=1", bus.stall); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rs_stall got=%0b want=0", bus.stall); end
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL rs_valid got=%0b want=0", bus.ex_valid); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rs_stall_cnt got=%0d want=0", stall_cnt); end
    total++; if (fwd_cnt !== 32'd0) begin bad++; $display("FAIL rs_fwd_cnt got=%0d want=0", fwd_cnt); end
    nop();
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, RS1_S1, IMM_S2, 1, 0, 1'b0, 5, 1'b1, 1'b1);  // LW x5
      step();
      issue(1'b1, RS1_S1, RS2_S2, 5, 1, 1'b0, 6, 1'b1, 1'b0);  // ADD x6,x5,x1
      step();
      step();
    end
    nop();
    step();
    total++; if (stall_cnt !== 32'd4) begin bad++; $display("FAIL sat_wide_stall got=%0d want=4", stall_cnt); end
    total++; if (fwd_cnt !== 32'd4) begin bad++; $display("FAIL sat_wide_fwd got=%0d want=4", fwd_cnt); end
    total++; if (sm_stall_cnt !== 2'd3) begin bad++; $display("FAIL sat_stall got=%0d want=3", sm_stall_cnt); end
    total++; if (sm_fwd_cnt !== 2'd3) begin bad++; $display("FAIL sat_fwd got=%0d want=3", sm_fwd_cnt); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance_two();
    test_load_use();
    test_store_after_load();
    test_x0_and_flush();
    test_enable_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
